// File: rtl/sync_fifo_fwft_adapter_if.sv
// Bundles the upstream FIFO read port and the downstream valid/ready stream
// seen by sync_fifo_fwft_adapter (master = adapter side).
interface sync_fifo_fwft_adapter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  fifo_re_o;
   logic [DATA_WIDTH-1:0] fifo_data_i;
   logic                  fifo_empty_i;
   logic [DATA_WIDTH-1:0] m_data_o;
   logic                  m_valid_o;
   logic                  m_ready_i;

   modport master (
      output fifo_re_o,
      input  fifo_data_i,
      input  fifo_empty_i,
      output m_data_o,
      output m_valid_o,
      input  m_ready_i
   );

   modport slave (
      input  fifo_re_o,
      output fifo_data_i,
      output fifo_empty_i,
      input  m_data_o,
      input  m_valid_o,
      output m_ready_i
   );
endinterface

// File: rtl/sync_fifo_fwft_adapter.sv
// FWFT adapter: 2-entry prefetch buffer turning a 1-cycle-latency FIFO read port
// into a valid/ready stream. Optional underrun counter: SYNC_FIFO_FWFT_UNDERRUN_CNT_EN.
module sync_fifo_fwft_adapter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   sync_fifo_fwft_adapter_if.master bus,
`ifdef SYNC_FIFO_FWFT_UNDERRUN_CNT_EN
   output logic [15:0]              underrun_cnt_o,
`endif
   output logic [1:0]               level_o
);

   logic [1:0]            count_q;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] tail_q;
   logic                  pop;
   logic                  push;
   logic                  fifo_re;
   logic [2:0]            occupancy;

   assign pop  = (count_q != 2'd0) & bus.m_ready_i;
   assign push = inflight_q & ~flush_i;

   // Credit counts the in-flight word and frees the slot being popped this cycle,
   // which is what lets a held-ready consumer see one word per cycle.
   assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign fifo_re   = rst_ni & ~bus.fifo_empty_i & ~flush_i & (occupancy < 3'd2);

   assign bus.fifo_re_o = fifo_re;
   assign bus.m_valid_o = (count_q != 2'd0);
   assign bus.m_data_o  = head_q;
   assign level_o       = count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         inflight_q <= fifo_re;
         if (flush_i) begin
            count_q <= 2'd0;
         end else begin
            case (count_q)
               2'd0: begin
                  if (push) begin
                     head_q  <= bus.fifo_data_i;
                     count_q <= 2'd1;
                  end
               end
               2'd1: begin
                  if (push && pop) begin
                     head_q <= bus.fifo_data_i;
                  end else if (push) begin
                     tail_q  <= bus.fifo_data_i;
                     count_q <= 2'd2;
                  end else if (pop) begin
                     count_q <= 2'd0;
                  end
               end
               2'd2: begin
                  // Push without pop cannot happen here: the credit rule blocks the read.
                  if (pop) begin
                     head_q <= tail_q;
                     if (push) begin
                        tail_q <= bus.fifo_data_i;
                     end else begin
                        count_q <= 2'd1;
                     end
                  end
               end
               default: count_q <= 2'd0;
            endcase
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_UNDERRUN_CNT_EN
   logic [15:0] underrun_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         underrun_q <= 16'd0;
      end else if (flush_i) begin
         underrun_q <= 16'd0;
      end else if (bus.m_ready_i && (count_q == 2'd0) && (underrun_q != 16'hFFFF)) begin
         underrun_q <= underrun_q + 16'd1;
      end
   end

   assign underrun_cnt_o = underrun_q;
`endif

endmodule
